rr_token_arbiter: RTL and testbench
===================================

# rr_token_arbiter

Round-robin arbiter that shares one resource among N requesters. A rotating one-hot priority token gives each requester its turn in order, the same way the 4-stage ring counter circulates a single 1. The block issues a one-hot grant and its binary index, so the grant can drive a shared datapath mux directly. It sits between the requesting agents and the shared resource and is the only block that sequences access to it.

## Interface
Parameters:
- N, default 4, number of requesters; must be at least 2.
- IDXW, default $clog2(N), width of the grant index.
- MAX_HOLD, default 8, maximum consecutive grant cycles; must be at least 1. Used only when the timeout feature is compiled in.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  N  level request per requester. It is held high for as long as the requester wants the resource.
- GNT  out  N  one-hot grant, registered. All zeros when idle.
- GNT_IDX  out  IDXW  binary index of the granted requester. Holds 0 when idle.
- BUSY  out  1  high whenever any GNT bit is high.
- TOKEN  out  N  one-hot priority pointer, registered.
- TMO  out  1  one-cycle pulse when a grant is forcibly revoked. Tied to 0 when the timeout feature is compiled out.

## Operation
States are ST_IDLE and ST_GRANT.

Winner search:
- Find the first i with REQ[i]=1, scanning circularly from the TOKEN position upward.
- When REQ is 0, there is no winner.

ST_IDLE:
- If a winner exists at the sampling edge: set GNT to onehot(winner), GNT_IDX to winner, BUSY to 1, clear the hold counter, and move to ST_GRANT.
- Otherwise stay in ST_IDLE.

ST_GRANT, while REQ[GNT_IDX]=1:
- The grant is held and the hold counter increments.
- Other requests have no effect.

Release, when REQ[GNT_IDX]=0 at an edge:
- TOKEN becomes onehot((GNT_IDX+1) mod N).
- The winner search reruns from the new TOKEN in the same edge, with the current holder excluded.
- If a winner exists, it is granted immediately, with no dead cycle. Otherwise go to ST_IDLE with GNT=0, GNT_IDX=0, BUSY=0.

General rules:
- TOKEN changes only on release or forced release. It never changes while idle.
- GNT is always zero or one-hot. GNT_IDX always encodes GNT.
- If a requester lowers REQ and raises it again before it has been regranted, it waits its turn by token order.
- Hold counter width is $clog2(MAX_HOLD+1). The counter saturates and never wraps.

## Timing
- REQ is sampled at edge k. GNT, GNT_IDX and BUSY are valid after edge k, so grant latency is 1 cycle.
- Release latency is 1 cycle: REQ low at edge j means GNT changes after edge j.
- Back-to-back handover takes 0 idle cycles.
- Simultaneous requests are resolved purely by token order.
- A simultaneous release and new request by the next-in-order requester is granted at the same edge.
- Reset values (asynchronous, taking effect immediately, including mid-grant):
  - State ST_IDLE, with GNT=0, GNT_IDX=0, BUSY=0 and TMO=0.
  - TOKEN = onehot(0), i.e. bit 0 set.
  - Hold counter = 0.
- First edge with RST_N high: normal sampling.

## Configuration
- RR_TIMEOUT_EN defined:
  - At an edge where the holder has been granted MAX_HOLD cycles and REQ[GNT_IDX] is still 1, a forced release occurs.
  - Forced release advances TOKEN exactly as a normal release does, and TMO pulses for 1 cycle after that edge.
  - The holder is excluded from that edge's winner search. If no other requester is active, GNT drops to 0 for exactly 1 cycle (ST_IDLE) and the former holder is regranted on the next edge.
- RR_TIMEOUT_EN undefined:
  - No hold limit; a holder keeps the grant indefinitely.
  - TMO is constant 0, MAX_HOLD is unused, and the counter logic is removed.

## Structure
- Package rr_arb_pkg holds:
  - The state typedef enum {ST_IDLE, ST_GRANT}.
  - A circular first-one search function (request vector and token in, index and valid out).
- Sub-module rr_onehot_enc is an N-to-IDXW one-hot-to-binary OR encoder, used for GNT_IDX. It generalises the existing 4-to-2 coder.

## Test plan
- Reset/idle: hold RST_N low, then release with REQ=0000 → GNT=0000, GNT_IDX=0, BUSY=0, TOKEN=0001, and nothing changes for 10 cycles.
- Single request: REQ=0100 at edge 3 → GNT=0100, GNT_IDX=2 after edge 3. Drop REQ at edge 6 → GNT=0000 after edge 6, TOKEN=1000.
- Fairness: TOKEN=0001, REQ=1111, each holder drops its request 2 cycles after being granted and reasserts 1 cycle later → grant order 0,1,2,3,0 with no idle gaps.
- Token priority: TOKEN=0100, REQ=0011 → GNT=0001, because the search wraps from 2 to 3 to 0.
- Reset mid-grant: GNT=0010, then pulse RST_N low between edges → GNT, BUSY and GNT_IDX clear immediately and TOKEN=0001.
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4):
  - REQ=0011 held, holder 0 → GNT=0001 for 4 cycles, then GNT=0010 with a TMO pulse and TOKEN=0010.
  - REQ=0001 held alone → a 1-cycle GNT=0000 gap, then GNT=0001 again.

Source files
------------

// File: rtl/rr_token_arbiter_pkg.sv
// Shared types and the circular first-one search for the round-robin token arbiter.
package rr_arb_pkg;

    typedef enum logic {ST_IDLE, ST_GRANT} state_e;

    localparam int MAX_N  = 32;
    localparam int MAX_IW = $clog2(MAX_N);

    // Scan req circularly upward from the set bit of token; lowest offset wins.
    function automatic void rr_search(
        input  logic [MAX_N-1:0] req,
        input  logic [MAX_N-1:0] token,
        input  int               n,
        output int               idx,
        output logic             vld
    );
        int tpos;
        int cand;
        tpos = 0;
        idx  = 0;
        vld  = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && token[i[MAX_IW-1:0]]) tpos = i;
        end
        for (int off = MAX_N - 1; off >= 0; off--) begin
            if (off < n) begin
                cand = tpos + off;
                if (cand >= n) cand = cand - n;
                if (req[cand[MAX_IW-1:0]]) begin
                    idx = cand;
                    vld = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_token_arbiter_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_token_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    REQ;
    logic [N-1:0]    GNT;
    logic [IDXW-1:0] GNT_IDX;
    logic            BUSY;
    logic [N-1:0]    TOKEN;
    logic            TMO;

    modport master (output REQ, input GNT, GNT_IDX, BUSY, TOKEN, TMO);
    modport slave  (input REQ, output GNT, GNT_IDX, BUSY, TOKEN, TMO);
endinterface

// File: rtl/rr_onehot_enc.sv
// N-to-IDXW one-hot to binary OR encoder; an all-zero input encodes to 0.
module rr_onehot_enc #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    onehot_i,
    output logic [IDXW-1:0] idx_o
);
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) idx_o = idx_o | IDXW'(i);
        end
    end
endmodule

// File: rtl/rr_token_arbiter.sv
// Round-robin token arbiter with registered one-hot grant and zero-gap handover.
// Optional hold limit with forced release is compiled in by defining RR_TIMEOUT_EN.
module rr_token_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    rr_token_arbiter_if.slave bus
);
    if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_param_check
        $error("rr_token_arbiter: N must be 2..%0d and MAX_HOLD at least 1", MAX_N);
    end

    state_e       state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [N-1:0] tok_q, tok_d;
    logic [N-1:0] tok_adv;
    logic         held, expire, release_ev;
    int           idle_idx, hand_idx;
    logic         idle_vld, hand_vld;

    assign held       = |(bus.REQ & gnt_q);
    // The token after a release is the holder's one-hot rotated up by one.
    assign tok_adv    = {gnt_q[N-2:0], gnt_q[N-1]};
    assign release_ev = (state_q == ST_GRANT) && (!held || expire);

    always_comb begin
        rr_search(MAX_N'(bus.REQ), MAX_N'(tok_q), N, idle_idx, idle_vld);
        rr_search(MAX_N'(bus.REQ & ~gnt_q), MAX_N'(tok_adv), N, hand_idx, hand_vld);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        tok_d   = tok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (idle_vld) begin
                    gnt_d   = N'(1) << idle_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_ev) begin
                    tok_d = tok_adv;
                    if (hand_vld) begin
                        gnt_d = N'(1) << hand_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            tok_q   <= N'(1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            tok_q   <= tok_d;
        end
    end

`ifdef RR_TIMEOUT_EN
    localparam int HOLDW = $clog2(MAX_HOLD + 1);

    logic [HOLDW-1:0] hold_q, hold_d;
    logic             tmo_q;

    // hold_q counts completed grant cycles, so MAX_HOLD-1 means this edge ends the MAX_HOLD-th.
    assign expire = (hold_q == HOLDW'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == ST_GRANT && held && !expire)
            hold_d = (hold_q == HOLDW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= release_ev && held;
        end
    end

    assign bus.TMO = tmo_q;
`else
    assign expire  = 1'b0;
    assign bus.TMO = 1'b0;
`endif

    rr_onehot_enc #(.N(N), .IDXW(IDXW)) u_enc (
        .onehot_i (gnt_q),
        .idx_o    (bus.GNT_IDX)
    );

    assign bus.GNT   = gnt_q;
    assign bus.BUSY  = |gnt_q;
    assign bus.TOKEN = tok_q;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Self-checking bench for rr_token_arbiter: directed scenarios plus randomized traffic
// against a turn-order reference model (hold-limit scenarios when RR_TIMEOUT_EN is defined).
module tb_rr_token_arbiter;
    localparam int N        = 4;
    localparam int IDXW     = 2;
    localparam int MAX_HOLD = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    int   checks = 0;
    int   passed = 0;

    rr_token_arbiter_if #(.N(N), .IDXW(IDXW)) bus ();

    rr_token_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: token position, current holder (-1 when idle), cycles held.
    int   m_tok;
    int   m_holder;
    int   m_cnt;
    logic m_tmo;

    function automatic int find_from(input logic [N-1:0] r, input int start);
        logic [N-1:0] sh;
        for (int off = 0; off < N; off++) begin
            sh = r >> ((start + off) % N);
            if (sh[0]) return (start + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_tok    = 0;
        m_holder = -1;
        m_cnt    = 0;
        m_tmo    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        logic [N-1:0] others;
        logic         still;
        logic         forced;
        m_tmo = 1'b0;
        if (m_holder < 0) begin
            m_holder = find_from(r, m_tok);
            m_cnt    = 0;
        end else begin
            others = r;
            others[m_holder] = 1'b0;
            still  = r[m_holder];
            forced = 1'b0;
`ifdef RR_TIMEOUT_EN
            forced = still && (m_cnt + 1 >= MAX_HOLD);
`endif
            if (still && !forced) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_tok    = (m_holder + 1) % N;
                m_tmo    = forced;
                m_holder = find_from(others, m_tok);
                m_cnt    = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return (m_holder >= 0) ? (N'(1) << m_holder) : '0;
    endfunction

    function automatic logic [IDXW-1:0] exp_idx();
        return (m_holder >= 0) ? IDXW'(m_holder) : '0;
    endfunction

    // Drive REQ for one sampling edge, advance the model, and settle past the edge.
    task automatic cycle(input logic [N-1:0] r);
        bus.REQ = r;
        @(posedge CLK);
        model_step(r);
        #1;
    endtask

    task automatic test_reset();
        bus.REQ = '0;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.GNT_IDX !== 2'd0 || bus.BUSY !== 1'b0 ||
            bus.TOKEN !== 4'b0001 || bus.TMO !== 1'b0)
            $display("FAIL reset_vals got gnt=%b idx=%0d busy=%b tok=%b tmo=%b exp 0000/0/0/0001/0",
                     bus.GNT, bus.GNT_IDX, bus.BUSY, bus.TOKEN, bus.TMO);
        else passed++;
        RST_N = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(4'b0000);
            checks++;
            if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.TOKEN !== 4'b0001)
                $display("FAIL idle_stable cyc=%0d got gnt=%b busy=%b tok=%b exp 0000/0/0001",
                         c, bus.GNT, bus.BUSY, bus.TOKEN);
            else passed++;
        end
    endtask

    task automatic test_single();
        cycle(4'b0100);
        checks++;
        if (bus.GNT !== 4'b0100 || bus.GNT_IDX !== 2'd2 || bus.BUSY !== 1'b1)
            $display("FAIL single_grant got gnt=%b idx=%0d busy=%b exp 0100/2/1",
                     bus.GNT, bus.GNT_IDX, bus.BUSY);
        else passed++;
        repeat (2) cycle(4'b0100);
        checks++;
        if (bus.GNT !== 4'b0100 || bus.TOKEN !== 4'b0001)
            $display("FAIL single_hold got gnt=%b tok=%b exp 0100/0001", bus.GNT, bus.TOKEN);
        else passed++;
        cycle(4'b0000);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.GNT_IDX !== 2'd0 || bus.BUSY !== 1'b0 || bus.TOKEN !== 4'b1000)
            $display("FAIL single_release got gnt=%b idx=%0d busy=%b tok=%b exp 0000/0/0/1000",
                     bus.GNT, bus.GNT_IDX, bus.BUSY, bus.TOKEN);
        else passed++;
    endtask

    task automatic test_token_priority();
        cycle(4'b0010);
        cycle(4'b0000);
        checks++;
        if (bus.TOKEN !== 4'b0100 || bus.GNT !== 4'b0000)
            $display("FAIL prio_setup got tok=%b gnt=%b exp 0100/0000", bus.TOKEN, bus.GNT);
        else passed++;
        cycle(4'b0011);
        checks++;
        if (bus.GNT !== 4'b0001 || bus.GNT_IDX !== 2'd0)
            $display("FAIL prio_wrap got gnt=%b idx=%0d exp 0001/0", bus.GNT, bus.GNT_IDX);
        else passed++;
        cycle(4'b0000);
        checks++;
        if (bus.TOKEN !== 4'b0010 || bus.BUSY !== 1'b0)
            $display("FAIL prio_release got tok=%b busy=%b exp 0010/0", bus.TOKEN, bus.BUSY);
        else passed++;
    endtask

    task automatic test_fairness();
        logic [N-1:0] r;
        logic [N-1:0] want;
        cycle(4'b1000);
        cycle(4'b0000);
        checks++;
        if (bus.TOKEN !== 4'b0001)
            $display("FAIL fair_setup got tok=%b exp 0001", bus.TOKEN);
        else passed++;
        for (int s = 0; s <= 8; s++) begin
            r = 4'b1111;
            if (s > 0 && s % 2 == 0) r[(s / 2 - 1) % N] = 1'b0;
            want = N'(1) << ((s / 2) % N);
            cycle(r);
            checks++;
            if (bus.GNT !== want || bus.BUSY !== 1'b1)
                $display("FAIL fair_order step=%0d got gnt=%b busy=%b exp %b/1", s, bus.GNT, bus.BUSY, want);
            else passed++;
        end
        cycle(4'b0000);
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            cycle(r);
            checks++;
            if (bus.GNT !== exp_gnt() || bus.GNT_IDX !== exp_idx() || bus.BUSY !== (m_holder >= 0))
                $display("FAIL rand_grant cyc=%0d req=%b got gnt=%b idx=%0d busy=%b exp %b/%0d/%b",
                         c, r, bus.GNT, bus.GNT_IDX, bus.BUSY, exp_gnt(), exp_idx(), m_holder >= 0);
            else passed++;
            checks++;
            if (bus.TOKEN !== (N'(1) << m_tok) || bus.TMO !== m_tmo)
                $display("FAIL rand_token cyc=%0d got tok=%b tmo=%b exp %b/%b",
                         c, bus.TOKEN, bus.TMO, N'(1) << m_tok, m_tmo);
            else passed++;
        end
        cycle(4'b0000);
        cycle(4'b0000);
    endtask

    task automatic test_reset_mid_grant();
        cycle(4'b0010);
        checks++;
        if (bus.GNT !== 4'b0010)
            $display("FAIL midrst_setup got gnt=%b exp 0010", bus.GNT);
        else passed++;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.GNT_IDX !== 2'd0 ||
            bus.TOKEN !== 4'b0001 || bus.TMO !== 1'b0)
            $display("FAIL midrst_clear got gnt=%b busy=%b idx=%0d tok=%b tmo=%b exp 0000/0/0/0001/0",
                     bus.GNT, bus.BUSY, bus.GNT_IDX, bus.TOKEN, bus.TMO);
        else passed++;
        model_reset();
        bus.REQ = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(4'b0100);
        checks++;
        if (bus.GNT !== 4'b0100 || bus.GNT_IDX !== 2'd2)
            $display("FAIL midrst_resume got gnt=%b idx=%0d exp 0100/2", bus.GNT, bus.GNT_IDX);
        else passed++;
        cycle(4'b0000);
    endtask

`ifdef RR_TIMEOUT_EN
    task automatic test_timeout();
        RST_N = 1'b0;
        #1;
        model_reset();
        bus.REQ = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < MAX_HOLD; c++) begin
            cycle(4'b0011);
            checks++;
            if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0)
                $display("FAIL tmo_hold cyc=%0d got gnt=%b tmo=%b exp 0001/0", c, bus.GNT, bus.TMO);
            else passed++;
        end
        cycle(4'b0011);
        checks++;
        if (bus.GNT !== 4'b0010 || bus.TMO !== 1'b1 || bus.TOKEN !== 4'b0010)
            $display("FAIL tmo_force got gnt=%b tmo=%b tok=%b exp 0010/1/0010", bus.GNT, bus.TMO, bus.TOKEN);
        else passed++;
        cycle(4'b0011);
        checks++;
        if (bus.GNT !== 4'b0010 || bus.TMO !== 1'b0)
            $display("FAIL tmo_pulse got gnt=%b tmo=%b exp 0010/0", bus.GNT, bus.TMO);
        else passed++;
        cycle(4'b0000);
        for (int c = 0; c < MAX_HOLD; c++) cycle(4'b0001);
        checks++;
        if (bus.GNT !== 4'b0001)
            $display("FAIL tmo_alone_hold got gnt=%b exp 0001", bus.GNT);
        else passed++;
        cycle(4'b0001);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b1 || bus.BUSY !== 1'b0)
            $display("FAIL tmo_gap got gnt=%b tmo=%b busy=%b exp 0000/1/0", bus.GNT, bus.TMO, bus.BUSY);
        else passed++;
        cycle(4'b0001);
        checks++;
        if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0)
            $display("FAIL tmo_regrant got gnt=%b tmo=%b exp 0001/0", bus.GNT, bus.TMO);
        else passed++;
        cycle(4'b0000);
    endtask
`endif

    initial begin
        bus.REQ = '0;
        model_reset();
        test_reset();
        test_single();
        test_token_priority();
        test_fairness();
        test_random();
        test_reset_mid_grant();
`ifdef RR_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
